// File: rtl/sbox_arbiter.sv
// Shares one S-box lookup port between the subbytes stage (requester 0) and
// the key schedule (requester 1). Ownership is granted per burst with a
// round-robin tie-break. Each S-box result is steered back to the requester
// that issued the lookup by a tag pipeline matching the S-box latency.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   req*_i, data*_i, decrypt*_i  per-requester burst request, byte, inverse select
//   gnt*_o                     per-requester ownership (registered state decode)
//   valid*_o, result*_o        per-requester S-box result, zero when not valid
//   sbox_data_o, sbox_decrypt_o  byte and inverse select driven to the S-box
//   sbox_data_i                S-box result, SBOX_LAT cycles after its input
//   busy_o                     an owner is present or lookups are in flight
module sbox_arbiter #(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic [7:0] data0_i,
  input  logic       decrypt0_i,
  output logic       gnt0_o,
  output logic       valid0_o,
  output logic [7:0] result0_o,
  input  logic       req1_i,
  input  logic [7:0] data1_i,
  input  logic       decrypt1_i,
  output logic       gnt1_o,
  output logic       valid1_o,
  output logic [7:0] result1_o,
  output logic [7:0] sbox_data_o,
  output logic       sbox_decrypt_o,
  input  logic [7:0] sbox_data_i,
  output logic       busy_o
);

  localparam int unsigned LAST = SBOX_LAT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state;
  logic                ptr;     // requester that wins a tie in IDLE
  logic                dec_q;   // last driven inverse select, held in IDLE
  logic [SBOX_LAT-1:0] tag_v;   // in-flight lookup valid per stage
  logic [SBOX_LAT-1:0] tag_o;   // in-flight lookup owner per stage (1 = req1)
  logic                acc0;
  logic                acc1;

  // A lookup is accepted only while the requester both owns and requests.
  assign acc0 = (state == OWN0) && req0_i;
  assign acc1 = (state == OWN1) && req1_i;

  assign gnt0_o = (state == OWN0);
  assign gnt1_o = (state == OWN1);

  assign sbox_data_o = acc0 ? data0_i : (acc1 ? data1_i : 8'h00);

  // Inverse select follows the owner; with no owner it keeps its last value.
  always_comb begin
    sbox_decrypt_o = dec_q;
    case (state)
      OWN0:    sbox_decrypt_o = decrypt0_i;
      OWN1:    sbox_decrypt_o = decrypt1_i;
      default: sbox_decrypt_o = dec_q;
    endcase
  end

  // Burst arbitration; every release hands priority to the other requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      dec_q <= sbox_decrypt_o;
      case (state)
        IDLE: begin
          if (req0_i && req1_i) state <= ptr ? OWN1 : OWN0;
          else if (req0_i)      state <= OWN0;
          else if (req1_i)      state <= OWN1;
        end
        OWN0: begin
          if (!req0_i) begin
            ptr   <= 1'b1;
            state <= req1_i ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!req1_i) begin
            ptr   <= 1'b0;
            state <= req0_i ? OWN0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag shift register aligned with the S-box pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= SBOX_LAT'({tag_v, acc0 | acc1});
      tag_o <= SBOX_LAT'({tag_o, acc1});
    end
  end

  assign valid0_o  = tag_v[LAST] && !tag_o[LAST];
  assign valid1_o  = tag_v[LAST] &&  tag_o[LAST];
  assign result0_o = valid0_o ? sbox_data_i : 8'h00;
  assign result1_o = valid1_o ? sbox_data_i : 8'h00;

  assign busy_o = (state != IDLE) || (|tag_v);

endmodule

// File: tb/tb_sbox_arbiter.sv
// Bench for sbox_arbiter: two instances (S-box latency 1 and 3) share one
// stimulus stream. A rule-level model predicts grants, S-box drive, routed
// results and busy, and is compared every cycle; literal checks pin the model.
module tb_sbox_arbiter;

  localparam int NC = 1024;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, dec0 = 1'b0, req1 = 1'b0, dec1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;

  logic       gnt0_w [2], gnt1_w [2], valid0_w [2], valid1_w [2];
  logic       sdec_w [2], busy_w [2];
  logic [7:0] result0_w [2], result1_w [2], sdata_w [2], sin_w [2];

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Rule-level model state.
  int       m_owner = 0;  // 0 none, 1 requester 0, 2 requester 1
  int       m_ptr = 0;
  logic     m_hold = 1'b0;
  int       m_last = -100;
  bit       ev [2][2][NC];
  logic [7:0] er [2][2][NC];

  // Observed result logs for literal checks.
  logic [7:0] r1v0 [$], r3v0 [$], r1v1 [$], r3v1 [$];
  int fv0 [2];
  int fg0 = -1;

  always #5 clk = ~clk;

  sbox_arbiter #(.SBOX_LAT(LAT_A)) u_a (
    .clk(clk), .reset(reset),
    .req0_i(req0), .data0_i(data0), .decrypt0_i(dec0),
    .gnt0_o(gnt0_w[0]), .valid0_o(valid0_w[0]), .result0_o(result0_w[0]),
    .req1_i(req1), .data1_i(data1), .decrypt1_i(dec1),
    .gnt1_o(gnt1_w[0]), .valid1_o(valid1_w[0]), .result1_o(result1_w[0]),
    .sbox_data_o(sdata_w[0]), .sbox_decrypt_o(sdec_w[0]),
    .sbox_data_i(sin_w[0]), .busy_o(busy_w[0]));

  sbox_arbiter #(.SBOX_LAT(LAT_B)) u_b (
    .clk(clk), .reset(reset),
    .req0_i(req0), .data0_i(data0), .decrypt0_i(dec0),
    .gnt0_o(gnt0_w[1]), .valid0_o(valid0_w[1]), .result0_o(result0_w[1]),
    .req1_i(req1), .data1_i(data1), .decrypt1_i(dec1),
    .gnt1_o(gnt1_w[1]), .valid1_o(valid1_w[1]), .result1_o(result1_w[1]),
    .sbox_data_o(sdata_w[1]), .sbox_decrypt_o(sdec_w[1]),
    .sbox_data_i(sin_w[1]), .busy_o(busy_w[1]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x, input logic inv);
    return inv ? inv_t[x] : fwd_t[x];
  endfunction

  // External S-box models with latency 1 and 3.
  logic [7:0] p1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    p1    <= sbox_f(sdata_w[0], sdec_w[0]);
    p3[0] <= sbox_f(sdata_w[1], sdec_w[1]);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign sin_w[0] = p1;
  assign sin_w[1] = p3[2];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, d, cyc, act, exp);
  endtask

  // Model: advance arbitration and schedule results once per cycle.
  always @(posedge clk) begin
    logic a0, a1, dc;
    logic [7:0] v;
    if (!reset) begin
      m_owner = 0; m_ptr = 0; m_hold = 1'b0; m_last = -100;
      for (int i = cyc + 1; i < NC; i++)
        for (int d = 0; d < 2; d++)
          for (int r = 0; r < 2; r++) ev[d][r][i] = 1'b0;
    end else begin
      a0 = (m_owner == 1) && req0;
      a1 = (m_owner == 2) && req1;
      dc = (m_owner == 1) ? dec0 : ((m_owner == 2) ? dec1 : m_hold);
      if (a0 || a1) begin
        v = sbox_f(a0 ? data0 : data1, dc);
        m_last = cyc;
        for (int d = 0; d < 2; d++) begin
          int idx;
          idx = cyc + ((d == 0) ? LAT_A : LAT_B);
          if (idx < NC) begin
            ev[d][a1 ? 1 : 0][idx] = 1'b1;
            er[d][a1 ? 1 : 0][idx] = v;
          end
        end
      end
      m_hold = dc;
      case (m_owner)
        0: begin
          if (req0 && req1) m_owner = m_ptr + 1;
          else if (req0)    m_owner = 1;
          else if (req1)    m_owner = 2;
        end
        1: if (!req0) begin m_ptr = 1; m_owner = req1 ? 2 : 0; end
        default: if (!req1) begin m_ptr = 0; m_owner = req0 ? 1 : 0; end
      endcase
    end
    cyc = cyc + 1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int eg0, eg1, ev0, ev1, er0, er1, esd, edc, eb;
      if (!reset) begin
        eg0 = 0; eg1 = 0; ev0 = 0; ev1 = 0; er0 = 0; er1 = 0; esd = 0; edc = 0; eb = 0;
      end else begin
        eg0 = (m_owner == 1) ? 1 : 0;
        eg1 = (m_owner == 2) ? 1 : 0;
        esd = (eg0 == 1 && req0) ? int'(data0) : ((eg1 == 1 && req1) ? int'(data1) : 0);
        edc = (m_owner == 1) ? int'(dec0) : ((m_owner == 2) ? int'(dec1) : int'(m_hold));
        ev0 = int'(ev[d][0][cyc]);
        ev1 = int'(ev[d][1][cyc]);
        er0 = (ev0 == 1) ? int'(er[d][0][cyc]) : 0;
        er1 = (ev1 == 1) ? int'(er[d][1][cyc]) : 0;
        eb  = (m_owner != 0 || (cyc - m_last) <= ((d == 0) ? LAT_A : LAT_B)) ? 1 : 0;
      end
      chk("gnt0", d, int'(gnt0_w[d]), eg0);
      chk("gnt1", d, int'(gnt1_w[d]), eg1);
      chk("valid0", d, int'(valid0_w[d]), ev0);
      chk("valid1", d, int'(valid1_w[d]), ev1);
      chk("result0", d, int'(result0_w[d]), er0);
      chk("result1", d, int'(result1_w[d]), er1);
      chk("sbox_data", d, int'(sdata_w[d]), esd);
      chk("sbox_decrypt", d, int'(sdec_w[d]), edc);
      chk("busy", d, int'(busy_w[d]), eb);
    end
  end

  // Log observed results for literal checks.
  always @(negedge clk) begin
    if (reset) begin
      if (valid0_w[0]) begin r1v0.push_back(result0_w[0]); if (fv0[0] < 0) fv0[0] = cyc; end
      if (valid0_w[1]) begin r3v0.push_back(result0_w[1]); if (fv0[1] < 0) fv0[1] = cyc; end
      if (valid1_w[0]) r1v1.push_back(result1_w[0]);
      if (valid1_w[1]) r3v1.push_back(result1_w[1]);
      if (gnt0_w[0] && fg0 < 0) fg0 = cyc;
    end
  end

  task automatic drive(input int r, input logic rq, input logic [7:0] dt, input logic dc);
    if (r == 0) begin req0 = rq; data0 = dt; dec0 = dc; end
    else begin req1 = rq; data1 = dt; dec1 = dc; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Requester behaviour: hold req, advance the byte only when accepted.
  task automatic burst(input int r, input logic [7:0] base, input int n, input logic dc,
                       input int dly);
    int k, t;
    logic acc;
    k = 0; t = 0;
    idle(dly);
    while (k < n && t < 100) begin
      drive(r, 1'b1, base + 8'(k), dc);
      acc = (m_owner == r + 1);
      @(posedge clk); #1; t++;
      if (acc) k++;
    end
    drive(r, 1'b0, 8'h00, dc);
    chk("burst_len", r, k, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    fv0[0] = -1; fv0[1] = -1;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, s;
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      fwd_t[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
    chk("tbl_fwd00", -1, int'(fwd_t[8'h00]), 'h63);
    chk("tbl_fwd01", -1, int'(fwd_t[8'h01]), 'h7c);
    chk("tbl_fwd53", -1, int'(fwd_t[8'h53]), 'hed);
    chk("tbl_inv63", -1, int'(inv_t[8'h63]), 'h00);

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Simultaneous requests after reset: requester 0 first, then 1 with no gap.
    fork
      burst(0, 8'h10, 3, 1'b0, 0);
      burst(1, 8'h20, 3, 1'b0, 0);
      begin
        @(negedge clk); @(negedge clk);
        chk("tie_gnt0", 0, int'(gnt0_w[0]), 1);
        chk("tie_gnt1", 0, int'(gnt1_w[0]), 0);
      end
    join
    idle(6);

    // Single 16-byte burst from requester 0.
    r1v0.delete(); r3v0.delete(); r1v1.delete(); r3v1.delete();
    fv0[0] = -1; fv0[1] = -1; fg0 = -1;
    t0 = cyc;
    burst(0, 8'h00, 16, 1'b0, 0);
    idle(6);
    chk("a_gnt_lat", 0, fg0, t0 + 1);
    chk("a_first_v_lat1", 0, fv0[0], t0 + 2);
    chk("a_first_v_lat3", 1, fv0[1], t0 + 4);
    chk("a_cnt_lat1", 0, r1v0.size(), 16);
    chk("a_cnt_lat3", 1, r3v0.size(), 16);
    chk("a_no_v1", 0, r1v1.size() + r3v1.size(), 0);
    chk("a_res0", 0, int'(r1v0[0]), 'h63);
    chk("a_res1", 0, int'(r1v0[1]), 'h7c);
    chk("a_res2", 0, int'(r1v0[2]), 'h77);
    chk("a_res3", 0, int'(r1v0[3]), 'h7b);
    chk("a_idle_busy", 1, int'(busy_w[1]), 0);

    // Simultaneous requests again: pointer now favours requester 1.
    fork
      burst(0, 8'h30, 2, 1'b0, 0);
      burst(1, 8'h38, 2, 1'b0, 0);
      begin
        @(negedge clk); @(negedge clk);
        chk("rr_gnt1", 0, int'(gnt1_w[0]), 1);
        chk("rr_gnt0", 0, int'(gnt0_w[0]), 0);
      end
    join
    idle(6);

    // Handover with requester 0's last lookup still in flight.
    fork
      burst(0, 8'h53, 1, 1'b0, 0);
      burst(1, 8'h40, 4, 1'b0, 1);
    join
    idle(6);
    chk("c_last0_lat1", 0, int'(r1v0[r1v0.size() - 1]), 'hed);
    chk("c_last0_lat3", 1, int'(r3v0[r3v0.size() - 1]), 'hed);

    // Inverse lookup by requester 1, then the select holds while idle.
    burst(1, 8'h63, 1, 1'b1, 0);
    idle(4);
    chk("d_inv_res", 0, int'(r1v1[r1v1.size() - 1]), 'h00);
    chk("d_hold_dec", 0, int'(sdec_w[0]), 1);
    chk("d_idle_data", 0, int'(sdata_w[0]), 0);

    // Reset in the middle of a burst with lookups in flight.
    fork
      burst(0, 8'h80, 10, 1'b0, 0);
      begin
        repeat (5) @(posedge clk);
        #1 chk("e_pre_busy", 1, int'(busy_w[1]), 1);
        #1 reset = 1'b0;
        #1;
        chk("e_rst_valid0", 1, int'(valid0_w[1]), 0);
        chk("e_rst_gnt0", 1, int'(gnt0_w[1]), 0);
        chk("e_rst_busy", 1, int'(busy_w[1]), 0);
        chk("e_rst_sdata", 0, int'(sdata_w[0]), 0);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
      end
    join
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
